// File: rtl/exec_scheduler.sv
// exec_scheduler: one-instruction-in-flight issue controller between
// decode and the ALU/STACK/JMP/DMA execution units.
module exec_scheduler #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ID_valid,
  input  logic [2:0]       ID_type,
  output logic             ID_ready,
  output logic             ALU_ENB,
  output logic             STACK_ENB,
  output logic             JMP_ENB,
  output logic             DMA_ENB,
  output logic             ALU_START,
  output logic             STACK_START,
  output logic             JMP_START,
  output logic             DMA_START,
  input  logic             ALU_DONE,
  input  logic             STACK_DONE,
  input  logic             JMP_DONE,
  input  logic             DMA_DONE,
  input  logic             FLUSH,
  output logic             COMPLETE,
  output logic [2:0]       COMPLETE_type,
  output logic             ILLEGAL_ERR,
  output logic             TIMEOUT_ERR,
  output logic [CNT_W-1:0] RETIRED_CNT
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  // unit vector order: {DMA, JMP, STACK, ALU}
  function automatic logic [3:0] unit_of(input logic [2:0] t);
    logic [3:0] u;
    u = 4'b0000;
    unique case (1'b1)
      t == 3'b001: u = 4'b0010;
      t == 3'b010,
      t == 3'b011: u = 4'b0001;
      t == 3'b100: u = 4'b1000;
      t == 3'b111: u = 4'b0100;
      default:     u = 4'b0000;
    endcase
    return u;
  endfunction

  state_t           state, state_nx;
  logic [2:0]       typ, typ_nx;
  logic [15:0]      cnt, cnt_nx;
  logic [3:0]       enb, enb_nx;
  logic [3:0]       start, start_nx;
  logic             comp_nx, ill_nx, tmo_err_nx;
  logic [2:0]       ctype_nx;
  logic [CNT_W-1:0] ret_nx;
  logic             legal, accept, done_hit, tmo;

  assign legal    = |unit_of(ID_type);
  assign accept   = (state == IDLE) && ID_valid && legal;
  assign done_hit = |(unit_of(typ) &
                      {DMA_DONE, JMP_DONE, STACK_DONE, ALU_DONE});
  assign tmo      = (cnt == 16'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (accept) state_nx = ISSUE;
      ISSUE: state_nx = FLUSH ? IDLE : WAIT;
      WAIT:  if (done_hit || FLUSH || tmo) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // next values of the registered outputs
  always_comb begin
    typ_nx     = accept ? ID_type : typ;
    enb_nx     = (state_nx != IDLE) ? unit_of(typ_nx) : 4'b0000;
    start_nx   = (state_nx == ISSUE) ? unit_of(typ_nx) : 4'b0000;
    comp_nx    = (state == WAIT) && done_hit;
    tmo_err_nx = (state == WAIT) && !done_hit && !FLUSH && tmo;
    ill_nx     = (state == IDLE) && ID_valid && !legal;
    ctype_nx   = comp_nx ? typ : COMPLETE_type;
    ret_nx     = comp_nx ? RETIRED_CNT + 1'b1 : RETIRED_CNT;
    cnt_nx     = cnt;
    if (state == ISSUE)     cnt_nx = 16'd0;
    else if (state == WAIT) cnt_nx = cnt + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      typ           <= 3'b000;
      cnt           <= 16'd0;
      enb           <= 4'b0000;
      start         <= 4'b0000;
      COMPLETE      <= 1'b0;
      COMPLETE_type <= 3'b000;
      ILLEGAL_ERR   <= 1'b0;
      TIMEOUT_ERR   <= 1'b0;
      RETIRED_CNT   <= '0;
    end else begin
      typ           <= typ_nx;
      cnt           <= cnt_nx;
      enb           <= enb_nx;
      start         <= start_nx;
      COMPLETE      <= comp_nx;
      COMPLETE_type <= ctype_nx;
      ILLEGAL_ERR   <= ill_nx;
      TIMEOUT_ERR   <= tmo_err_nx;
      RETIRED_CNT   <= ret_nx;
    end
  end

  assign ID_ready    = (state == IDLE);
  assign ALU_ENB     = enb[0];
  assign STACK_ENB   = enb[1];
  assign JMP_ENB     = enb[2];
  assign DMA_ENB     = enb[3];
  assign ALU_START   = start[0];
  assign STACK_START = start[1];
  assign JMP_START   = start[2];
  assign DMA_START   = start[3];

endmodule

// File: tb/tb_exec_scheduler.sv
// Directed bench for exec_scheduler with a retirement scoreboard.
// Small TIMEOUT and CNT_W make timeout and counter wrap cheap to reach.
module tb_exec_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ID_valid;
  logic [2:0] ID_type;
  logic       ID_ready;
  logic       ALU_ENB, STACK_ENB, JMP_ENB, DMA_ENB;
  logic       ALU_START, STACK_START, JMP_START, DMA_START;
  logic [3:0] done;
  logic       FLUSH;
  logic       COMPLETE;
  logic [2:0] COMPLETE_type;
  logic       ILLEGAL_ERR, TIMEOUT_ERR;
  logic [3:0] RETIRED_CNT;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [2:0] t;
    logic [3:0] c;
  } ret_t;

  ret_t       q[$];
  logic [3:0] mcnt = 4'd0;

  always #5 clk = ~clk;

  exec_scheduler #(.TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ID_valid(ID_valid), .ID_type(ID_type), .ID_ready(ID_ready),
    .ALU_ENB(ALU_ENB), .STACK_ENB(STACK_ENB),
    .JMP_ENB(JMP_ENB), .DMA_ENB(DMA_ENB),
    .ALU_START(ALU_START), .STACK_START(STACK_START),
    .JMP_START(JMP_START), .DMA_START(DMA_START),
    .ALU_DONE(done[0]), .STACK_DONE(done[1]),
    .JMP_DONE(done[2]), .DMA_DONE(done[3]),
    .FLUSH(FLUSH), .COMPLETE(COMPLETE), .COMPLETE_type(COMPLETE_type),
    .ILLEGAL_ERR(ILLEGAL_ERR), .TIMEOUT_ERR(TIMEOUT_ERR),
    .RETIRED_CNT(RETIRED_CNT)
  );

  wire [3:0] enb   = {DMA_ENB, JMP_ENB, STACK_ENB, ALU_ENB};
  wire [3:0] start = {DMA_START, JMP_START, STACK_START, ALU_START};

  // {DMA, JMP, STACK, ALU}
  function automatic logic [3:0] unit(input logic [2:0] t);
    case (t)
      3'b001:         return 4'b0010;
      3'b010, 3'b011: return 4'b0001;
      3'b100:         return 4'b1000;
      3'b111:         return 4'b0100;
      default:        return 4'b0000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_ret(input logic [2:0] t);
    mcnt = mcnt + 4'd1;
    q.push_back('{t: t, c: mcnt});
  endtask

  task automatic mon();
    ret_t e;
    if (COMPLETE) begin
      if (q.size() == 0) begin
        chk("unexpected_complete", 1, 0);
      end else begin
        e = q.pop_front();
        chk("complete_type", 32'(COMPLETE_type), 32'(e.t));
        chk("retired_cnt", 32'(RETIRED_CNT), 32'(e.c));
        chk("complete_no_err", 32'({ILLEGAL_ERR, TIMEOUT_ERR}), 0);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    mon();
  endtask

  task automatic run_ok(input logic [2:0] t);
    ID_valid = 1'b1;
    ID_type  = t;
    chk("ready_idle", 32'(ID_ready), 1);
    tick();
    ID_valid = 1'b0;
    chk("issue_enb", 32'(enb), 32'(unit(t)));
    chk("issue_start", 32'(start), 32'(unit(t)));
    chk("ready_busy", 32'(ID_ready), 0);
    tick();
    chk("wait_enb", 32'(enb), 32'(unit(t)));
    chk("wait_start", 32'(start), 0);
    done = unit(t);
    expect_ret(t);
    tick();
    done = 4'b0000;
    chk("retire_enb", 32'(enb), 0);
    chk("retire_complete", 32'(COMPLETE), 1);
    chk("retire_ready", 32'(ID_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int enb_cyc, te_cnt, te_at;
    rst_n    = 1'b0;
    ID_valid = 1'b0;
    ID_type  = 3'b000;
    done     = 4'b0000;
    FLUSH    = 1'b0;
    #2;
    chk("rst_ready", 32'(ID_ready), 1);
    chk("rst_enb", 32'(enb), 0);
    chk("rst_start", 32'(start), 0);
    chk("rst_ctype", 32'(COMPLETE_type), 0);
    chk("rst_cnt", 32'(RETIRED_CNT), 0);
    chk("rst_pulses", 32'({COMPLETE, ILLEGAL_ERR, TIMEOUT_ERR}), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // ALU2 then ALU1 accepted 3 cycles later
    run_ok(3'b011);
    run_ok(3'b010);

    // illegal type followed at once by STACK
    ID_valid = 1'b1;
    ID_type  = 3'b110;
    tick();
    chk("ill_pulse", 32'(ILLEGAL_ERR), 1);
    chk("ill_enb", 32'(enb), 0);
    chk("ill_start", 32'(start), 0);
    chk("ill_ready", 32'(ID_ready), 1);
    ID_type = 3'b001;
    tick();
    ID_valid = 1'b0;
    chk("ill_once", 32'(ILLEGAL_ERR), 0);
    chk("stack_start", 32'(start), 32'(4'b0010));
    tick();
    done = 4'b0010;
    expect_ret(3'b001);
    tick();
    done = 4'b0000;
    chk("stack_complete", 32'(COMPLETE), 1);

    // DMA timeout with TIMEOUT=4
    ID_valid = 1'b1;
    ID_type  = 3'b100;
    tick();
    ID_valid = 1'b0;
    enb_cyc = 0;
    te_cnt  = 0;
    te_at   = -1;
    for (int i = 0; i < 10; i++) begin
      if (DMA_ENB) enb_cyc++;
      if (TIMEOUT_ERR) begin
        te_cnt++;
        te_at = i;
      end
      tick();
    end
    chk("tmo_enb_cycles", 32'(enb_cyc), 5);
    chk("tmo_pulses", 32'(te_cnt), 1);
    chk("tmo_latency", 32'(te_at), 5);
    chk("tmo_ready", 32'(ID_ready), 1);

    // JMP: foreign DONE ignored, DONE beats FLUSH
    ID_valid = 1'b1;
    ID_type  = 3'b111;
    tick();
    ID_valid = 1'b0;
    tick();
    done = 4'b0010;
    tick();
    done = 4'b0000;
    chk("jmp_stack_done_ign", 32'(COMPLETE), 0);
    chk("jmp_still_enb", 32'(JMP_ENB), 1);
    done  = 4'b0100;
    FLUSH = 1'b1;
    expect_ret(3'b111);
    tick();
    done  = 4'b0000;
    FLUSH = 1'b0;
    chk("jmp_done_flush", 32'(COMPLETE), 1);

    // JMP aborted by FLUSH alone
    ID_valid = 1'b1;
    tick();
    ID_valid = 1'b0;
    tick();
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    chk("flush_enb", 32'(enb), 0);
    chk("flush_no_complete", 32'(COMPLETE), 0);
    chk("flush_ready", 32'(ID_ready), 1);
    te_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (TIMEOUT_ERR) te_cnt++;
      tick();
    end
    chk("flush_no_tmo", 32'(te_cnt), 0);

    // FLUSH in IDLE still accepts; FLUSH in ISSUE aborts
    FLUSH    = 1'b1;
    ID_valid = 1'b1;
    ID_type  = 3'b010;
    tick();
    ID_valid = 1'b0;
    chk("idle_flush_accept", 32'(ALU_START), 1);
    tick();
    FLUSH = 1'b0;
    chk("issue_flush_enb", 32'(enb), 0);
    chk("issue_flush_ready", 32'(ID_ready), 1);
    tick();
    chk("issue_flush_no_complete", 32'(COMPLETE), 0);

    // reset while DMA sits in WAIT
    ID_valid = 1'b1;
    ID_type  = 3'b100;
    tick();
    ID_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_enb", 32'(enb), 0);
    chk("mid_rst_ready", 32'(ID_ready), 1);
    chk("mid_rst_cnt", 32'(RETIRED_CNT), 0);
    chk("mid_rst_pulses", 32'({COMPLETE, ILLEGAL_ERR, TIMEOUT_ERR}), 0);
    tick();
    rst_n = 1'b1;
    mcnt  = 4'd0;
    tick();
    chk("post_rst_no_complete", 32'(COMPLETE), 0);

    // 17 back-to-back ALU ops: count runs 1..15, 0, 1
    for (int i = 0; i < 17; i++) run_ok(i[0] ? 3'b011 : 3'b010);
    chk("wrap_final", 32'(RETIRED_CNT), 1);
    chk("scoreboard_drained", 32'(q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
